matching_stage_nlane: RTL and testbench
=======================================

# matching_stage_nlane

Parametrised successor to the two-word matching stage in the compressor front end. It accepts a batch of LANES 32-bit words per cycle under a valid/ready handshake. Each word is classified against zero patterns and a DICT_ENTRY-deep FIFO dictionary, and the result is registered for the encoding stage. Intra-batch matching is sequential-equivalent: lane k sees the dictionary as it stands after lanes 0..k-1 have been processed, so the decompressor can replay lanes in order.

## Interface
Parameters:
- LANES, 2: words per batch, 1..8
- DICT_ENTRY, 16: dictionary depth, power of two, 2..64
- LOC_W, $clog2(DICT_ENTRY): location width (derived)

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous, active-low reset
- i_valid  in  1  batch valid
- o_ready  out  1  batch accepted when i_valid && o_ready
- i_word  in  32*LANES  lane k at [32k+31:32k]
- i_flush  in  1  clear dictionary, single-cycle pulse
- o_valid  out  1  registered result valid
- i_ready  in  1  downstream accepts result
- o_word  out  32*LANES  registered copy of accepted words
- o_code  out  3*LANES  per-lane match_code_t
- o_location  out  LOC_W*LANES  per-lane dictionary slot, 0 when unused

## Operation
- Codes: ZZZZ=0, XXXX=1, MMMM=2, MMXX=3, ZZZX=4, MMMX=5.
  - ZZZZ: word==0.
  - ZZZX: [31:8]==0.
  - MMMM: full match against a valid entry.
  - MMMX: [31:8] match.
  - MMXX: [31:16] match.
  - XXXX: none of the above.
- Priority: ZZZZ > MMMM > ZZZX > MMMX > MMXX > XXXX.
- Location tie-break: lowest slot index among entries matching at the winning level.
- Dictionary: DICT_ENTRY x 32 data, a per-entry valid bit, and write pointer wr_ptr. Invalid entries never match.
- Push rule: the word is pushed iff its code is MMMX, MMXX or XXXX.
- Push order: pushes go in lane order to slots wr_ptr, wr_ptr+1, … mod DICT_ENTRY, overwriting the oldest entry. wr_ptr advances by the push count, wrapping modulo DICT_ENTRY.
- Per-lane view: lane k's view = committed dictionary with the slots written by lanes j<k replaced by those lanes' words. A slot overwritten earlier in the batch is never matched with its old contents.
- Dictionary, wr_ptr and valid bits update only on an accepted batch, or on flush.
- i_flush: clears all valid bits and sets wr_ptr to 0.
  - Flush together with an accepted batch: the flush applies first. The batch matches against an empty dictionary, and its pushes land from slot 0.
- Reset (i_reset==0 at an edge) clears:
  - o_valid, o_word, o_code, o_location → 0
  - wr_ptr → 0
  - all valid bits → 0
  - dictionary data → 0
- o_ready is 0 while i_reset is low.

## Timing
- Latency: 1 cycle. The batch accepted at edge n appears on o_* after edge n, with o_valid=1.
- o_ready = !o_valid || i_ready (combinational). Full throughput is 1 batch/cycle, back-to-back.
- A batch accepted at edge n is visible in the dictionary for the batch accepted at edge n+1.
- When o_valid && !i_ready:
  - o_* hold stable and o_ready=0.
  - The dictionary is frozen; i_flush is still honoured.
- The output register loads only on acceptance. o_valid clears when i_ready && !(i_valid && o_ready).
- Reset mid-stream discards the in-flight result and all dictionary state. No partial batch survives.

## Structure
- Package matching_pkg:
  - match_code_t enum with the values above
  - constants WORD_W=32, MMMX_HI=8, MMXX_HI=16
  - function code_pushes(match_code_t)
- Sub-module lane_matcher:
  - Inputs: one word and a flattened dictionary view with valid bits.
  - Outputs: code and location, combinational.
  - Instantiate LANES times via generate.
  - View chaining is built in the top level from push masks and slot offsets.
- Top level holds the dictionary registers, wr_ptr, the handshake and the output register. Target size is 200–350 lines.

## Test plan
- LANES=2, DICT_ENTRY=16, after reset: batch {0x00000000, 0x00000012} → ZZZZ/loc0 and ZZZX/loc0; o_valid one cycle later; no pushes, wr_ptr=0.
- Empty dictionary, batch {0xDEADBEEF, 0xDEADBEEF} → XXXX (pushed to slot 0) and MMMM/loc0 (intra-batch forwarding).
  - Next batch {0xDEADBE00, 0xDEAD0000} → MMMX/loc0 and MMXX/loc0; pushes land in slots 1 and 2.
- Wrap-around: push 0xA0000000+(i<<16) for i=0..17 over 9 batches, then query {0xA0020000, 0xA0000000} → MMMM/loc2 and XXXX. Slot 0 now holds i=16 and wr_ptr=2.
- Overwrite hazard, DICT_ENTRY=2: dictionary {A=0x11110000 at slot 0, B=0x22220000 at slot 1}, wr_ptr=0. Batch {0x33330000, 0x11110000} → XXXX (evicts slot 0) and XXXX; lane 1 must NOT report MMMM/loc0.
- Backpressure: i_ready=0 for 3 cycles with o_valid=1 → o_ready=0, o_* stable, dictionary unchanged. A held second batch is accepted on the first cycle after i_ready=1, with its result one cycle later.
- Flush: after 0xCAFEF00D has been pushed, pulse i_flush together with batch {0xCAFEF00D, 0xCAFEF00D} → XXXX (pushed to slot 0) and MMMM/loc0.
- Reset mid-stream: assert reset with o_valid=1 → o_valid=0 on the next edge. The previously pushed word then returns XXXX.

Source files
------------

// File: rtl/matching_pkg.sv
// Shared types and constants for the N-lane dictionary matching stage.
package matching_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned MMMX_HI = 8;
  localparam int unsigned MMXX_HI = 16;
  localparam int unsigned CODE_W  = 3;

  typedef enum logic [CODE_W-1:0] {
    ZZZZ = 3'd0,
    XXXX = 3'd1,
    MMMM = 3'd2,
    MMXX = 3'd3,
    ZZZX = 3'd4,
    MMMX = 3'd5
  } match_code_t;

  // Words that are not reproducible from zero patterns or an exact hit enter the dictionary.
  function automatic logic code_pushes(input match_code_t code);
    return (code == MMMX) || (code == MMXX) || (code == XXXX);
  endfunction

endpackage

// File: rtl/lane_matcher.sv
// Classifies one word against a dictionary view; purely combinational.
module lane_matcher
  import matching_pkg::*;
#(
  parameter int unsigned DICT_ENTRY = 16,
  parameter int unsigned LOC_W      = $clog2(DICT_ENTRY)
) (
  input  logic [WORD_W-1:0]            word,
  input  logic [DICT_ENTRY*WORD_W-1:0] dict_data,
  input  logic [DICT_ENTRY-1:0]        dict_valid,
  output match_code_t                  code,
  output logic [LOC_W-1:0]             location
);

  logic             full_hit;
  logic             mmmx_hit;
  logic             mmxx_hit;
  logic [LOC_W-1:0] full_loc;
  logic [LOC_W-1:0] mmmx_loc;
  logic [LOC_W-1:0] mmxx_loc;

  // Lowest matching slot per match level; the first hit in ascending order is kept.
  always_comb begin
    full_hit = 1'b0;
    mmmx_hit = 1'b0;
    mmxx_hit = 1'b0;
    full_loc = '0;
    mmmx_loc = '0;
    mmxx_loc = '0;
    for (int i = 0; i < int'(DICT_ENTRY); i++) begin
      if (dict_valid[i]) begin
        if (!full_hit && (dict_data[i*WORD_W +: WORD_W] == word)) begin
          full_hit = 1'b1;
          full_loc = LOC_W'(i);
        end
        if (!mmmx_hit &&
            (dict_data[i*WORD_W+MMMX_HI +: WORD_W-MMMX_HI] == word[WORD_W-1:MMMX_HI])) begin
          mmmx_hit = 1'b1;
          mmmx_loc = LOC_W'(i);
        end
        if (!mmxx_hit &&
            (dict_data[i*WORD_W+MMXX_HI +: WORD_W-MMXX_HI] == word[WORD_W-1:MMXX_HI])) begin
          mmxx_hit = 1'b1;
          mmxx_loc = LOC_W'(i);
        end
      end
    end
  end

  always_comb begin
    code     = XXXX;
    location = '0;
    if (word == '0) begin
      code = ZZZZ;
    end else if (full_hit) begin
      code     = MMMM;
      location = full_loc;
    end else if (word[WORD_W-1:MMMX_HI] == '0) begin
      code = ZZZX;
    end else if (mmmx_hit) begin
      code     = MMMX;
      location = mmmx_loc;
    end else if (mmxx_hit) begin
      code     = MMXX;
      location = mmxx_loc;
    end
  end

endmodule

// File: rtl/matching_stage_nlane.sv
// N-lane dictionary matching stage: lane k matches against the dictionary as updated
// by lanes 0..k-1 of the same batch, then the batch result is registered.
module matching_stage_nlane
  import matching_pkg::*;
#(
  parameter int unsigned LANES      = 2,
  parameter int unsigned DICT_ENTRY = 16,
  parameter int unsigned LOC_W      = $clog2(DICT_ENTRY)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [WORD_W*LANES-1:0]   i_word,
  input  logic                      i_flush,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic [WORD_W*LANES-1:0]   o_word,
  output logic [CODE_W*LANES-1:0]   o_code,
  output logic [LOC_W*LANES-1:0]    o_location
);

  localparam int unsigned DICT_W = DICT_ENTRY * WORD_W;

  logic [DICT_W-1:0]        dict_data_q;
  logic [DICT_ENTRY-1:0]    dict_valid_q;
  logic [LOC_W-1:0]         wr_ptr_q;
  logic                     accept;
  logic [CODE_W*LANES-1:0]  code_flat;
  logic [LOC_W*LANES-1:0]   loc_flat;

  assign o_ready = i_reset && (!o_valid || i_ready);
  assign accept  = i_valid && o_ready;

  // View chain: each lane sees the previous lane's post-push dictionary.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [DICT_W-1:0]     view_data;
    logic [DICT_ENTRY-1:0] view_valid;
    logic [LOC_W-1:0]      view_ptr;
    logic [DICT_W-1:0]     next_data;
    logic [DICT_ENTRY-1:0] next_valid;
    logic [LOC_W-1:0]      next_ptr;
    logic [WORD_W-1:0]     lane_word;
    match_code_t           lane_code;
    logic [LOC_W-1:0]      lane_loc;
    logic                  push;

    // Flush takes effect before the first lane, so a flushed batch starts empty at slot 0.
    if (k == 0) begin : g_head
      assign view_data  = dict_data_q;
      assign view_valid = i_flush ? '0 : dict_valid_q;
      assign view_ptr   = i_flush ? '0 : wr_ptr_q;
    end else begin : g_link
      assign view_data  = g_lane[k-1].next_data;
      assign view_valid = g_lane[k-1].next_valid;
      assign view_ptr   = g_lane[k-1].next_ptr;
    end

    assign lane_word = i_word[k*WORD_W +: WORD_W];

    lane_matcher #(
      .DICT_ENTRY (DICT_ENTRY),
      .LOC_W      (LOC_W)
    ) u_matcher (
      .word       (lane_word),
      .dict_data  (view_data),
      .dict_valid (view_valid),
      .code       (lane_code),
      .location   (lane_loc)
    );

    assign push = code_pushes(lane_code);

    always_comb begin
      next_data  = view_data;
      next_valid = view_valid;
      for (int s = 0; s < int'(DICT_ENTRY); s++) begin
        if (push && (view_ptr == LOC_W'(s))) begin
          next_data[s*WORD_W +: WORD_W] = lane_word;
          next_valid[s]                 = 1'b1;
        end
      end
    end

    // Power-of-two depth makes the natural pointer overflow the modulo wrap.
    assign next_ptr = view_ptr + LOC_W'(push);

    assign code_flat[k*CODE_W +: CODE_W] = lane_code;
    assign loc_flat[k*LOC_W +: LOC_W]    = lane_loc;
  end

  // Dictionary commits only on acceptance; a lone flush is honoured even while stalled.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      dict_data_q  <= '0;
      dict_valid_q <= '0;
      wr_ptr_q     <= '0;
    end else if (accept) begin
      dict_data_q  <= g_lane[LANES-1].next_data;
      dict_valid_q <= g_lane[LANES-1].next_valid;
      wr_ptr_q     <= g_lane[LANES-1].next_ptr;
    end else if (i_flush) begin
      dict_valid_q <= '0;
      wr_ptr_q     <= '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      o_valid    <= 1'b0;
      o_word     <= '0;
      o_code     <= '0;
      o_location <= '0;
    end else if (accept) begin
      o_valid    <= 1'b1;
      o_word     <= i_word;
      o_code     <= code_flat;
      o_location <= loc_flat;
    end else if (i_ready) begin
      o_valid    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matching_stage_nlane.sv
// Bench for matching_stage_nlane: two instances (16-deep and 2-deep) share stimulus and
// are checked every cycle against a sequential lane-replay model, plus literal pins.
module tb_matching_stage_nlane;

  localparam int LANES = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid;
  logic        i_flush;
  logic        i_ready;
  logic [63:0] i_word;

  logic        a_ready, a_valid;
  logic [63:0] a_word;
  logic [5:0]  a_code;
  logic [7:0]  a_loc;
  logic        b_ready, b_valid;
  logic [63:0] b_word;
  logic [5:0]  b_code;
  logic [1:0]  b_loc;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  logic [31:0] m_data [2][16];
  bit          m_vld  [2][16];
  int          m_ptr  [2];
  int          m_depth[2];
  bit          m_ovalid[2];
  logic [31:0] m_word [2][2];
  int          m_code [2][2];
  int          m_loc  [2][2];

  always #5 clk = ~clk;

  matching_stage_nlane #(.LANES(2), .DICT_ENTRY(16)) dut_a (
    .i_clk(clk), .i_reset(rst_n), .i_valid(i_valid), .o_ready(a_ready),
    .i_word(i_word), .i_flush(i_flush), .o_valid(a_valid), .i_ready(i_ready),
    .o_word(a_word), .o_code(a_code), .o_location(a_loc)
  );

  matching_stage_nlane #(.LANES(2), .DICT_ENTRY(2)) dut_b (
    .i_clk(clk), .i_reset(rst_n), .i_valid(i_valid), .o_ready(b_ready),
    .i_word(i_word), .i_flush(i_flush), .o_valid(b_valid), .i_ready(i_ready),
    .o_word(b_word), .o_code(b_code), .o_location(b_loc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Codes: 0 ZZZZ, 1 XXXX, 2 MMMM, 3 MMXX, 4 ZZZX, 5 MMMX.
  function automatic void classify(input int d, input logic [31:0] w,
                                   output int code, output int loc);
    int f, h24, h16;
    f = -1; h24 = -1; h16 = -1;
    for (int s = m_depth[d] - 1; s >= 0; s--) begin
      if (m_vld[d][s]) begin
        if (m_data[d][s] == w)               f   = s;
        if (m_data[d][s][31:8] == w[31:8])   h24 = s;
        if (m_data[d][s][31:16] == w[31:16]) h16 = s;
      end
    end
    loc = 0;
    if (w == 32'h0)                  code = 0;
    else if (f >= 0)   begin code = 2; loc = f;   end
    else if (w[31:8] == 24'h0)       code = 4;
    else if (h24 >= 0) begin code = 5; loc = h24; end
    else if (h16 >= 0) begin code = 3; loc = h16; end
    else                             code = 1;
  endfunction

  // Model: replay lanes one at a time against a plain array dictionary.
  always @(posedge clk) begin : model
    bit          acc;
    logic [31:0] w;
    int          c, l;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        for (int s = 0; s < 16; s++) begin
          m_data[d][s] = 32'h0;
          m_vld[d][s]  = 1'b0;
        end
        m_ptr[d] = 0;
        m_ovalid[d] = 1'b0;
        for (int k = 0; k < LANES; k++) begin
          m_word[d][k] = 32'h0; m_code[d][k] = 0; m_loc[d][k] = 0;
        end
      end else begin
        acc = i_valid && (!m_ovalid[d] || i_ready);
        if (i_flush) begin
          for (int s = 0; s < 16; s++) m_vld[d][s] = 1'b0;
          m_ptr[d] = 0;
        end
        if (acc) begin
          for (int k = 0; k < LANES; k++) begin
            w = i_word[32*k +: 32];
            classify(d, w, c, l);
            m_word[d][k] = w; m_code[d][k] = c; m_loc[d][k] = l;
            if (c == 1 || c == 3 || c == 5) begin
              m_data[d][m_ptr[d]] = w;
              m_vld[d][m_ptr[d]]  = 1'b1;
              m_ptr[d] = (m_ptr[d] + 1) % m_depth[d];
            end
          end
          m_ovalid[d] = 1'b1;
        end else if (i_ready) begin
          m_ovalid[d] = 1'b0;
        end
      end
    end
    started = 1'b1;
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin : compare
    logic        act_rdy, act_vld;
    logic [31:0] act_word, act_code, act_loc;
    if (started) begin
      for (int d = 0; d < 2; d++) begin
        act_rdy = (d == 0) ? a_ready : b_ready;
        act_vld = (d == 0) ? a_valid : b_valid;
        chk($sformatf("d%0d_ready", d), 32'(act_rdy), 32'(rst_n && (!m_ovalid[d] || i_ready)));
        chk($sformatf("d%0d_valid", d), 32'(act_vld), 32'(m_ovalid[d]));
        for (int k = 0; k < LANES; k++) begin
          act_word = (d == 0) ? a_word[32*k +: 32] : b_word[32*k +: 32];
          act_code = (d == 0) ? 32'(a_code[3*k +: 3]) : 32'(b_code[3*k +: 3]);
          act_loc  = (d == 0) ? 32'(a_loc[4*k +: 4])  : 32'(b_loc[k]);
          chk($sformatf("d%0d_l%0d_word", d, k), act_word, m_word[d][k]);
          chk($sformatf("d%0d_l%0d_code", d, k), act_code, 32'(m_code[d][k]));
          chk($sformatf("d%0d_l%0d_loc",  d, k), act_loc,  32'(m_loc[d][k]));
        end
      end
    end
  end

  task automatic send(input logic [31:0] w0, input logic [31:0] w1, input logic fl);
    bit rdy;
    int n;
    i_valid = 1'b1; i_word = {w1, w0}; i_flush = fl; n = 0;
    do begin
      @(negedge clk); rdy = a_ready;
      @(posedge clk); #2;
      n++;
    end while (!rdy && n < 20);
    if (!rdy) chk("accept_timeout", 32'd0, 32'd1);
    i_valid = 1'b0; i_flush = 1'b0; i_word = '0;
  endtask

  task automatic pin_a(input string name, input int c0, input int l0, input int c1, input int l1);
    chk({name, "_a_c0"}, 32'(a_code[2:0]), 32'(c0));
    chk({name, "_a_l0"}, 32'(a_loc[3:0]),  32'(l0));
    chk({name, "_a_c1"}, 32'(a_code[5:3]), 32'(c1));
    chk({name, "_a_l1"}, 32'(a_loc[7:4]),  32'(l1));
  endtask

  initial begin
    m_depth[0] = 16; m_depth[1] = 2;
    rst_n = 1'b0; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1; i_word = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready", 32'(a_ready), 32'd0);
    chk("rst_valid", 32'(a_valid), 32'd0);
    chk("rst_word",  a_word[31:0], 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #2;

    send(32'h0000_0000, 32'h0000_0012, 1'b0);
    chk("zero_valid", 32'(a_valid), 32'd1);
    pin_a("zero", 0, 0, 4, 0);
    chk("zero_b_c1", 32'(b_code[5:3]), 32'd4);

    send(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0);
    pin_a("fwd", 1, 0, 2, 0);
    send(32'hDEAD_BE00, 32'hDEAD_0000, 1'b0);
    pin_a("part", 5, 0, 3, 0);
    send(32'hDEAD_BE00, 32'hDEAD_0000, 1'b0);
    pin_a("slots", 2, 1, 2, 2);

    for (int b = 0; b < 9; b++)
      send(32'hA000_0000 + (32'(2*b) << 16), 32'hA000_0000 + (32'(2*b+1) << 16), b == 0);
    send(32'hA002_0000, 32'hA000_0000, 1'b0);
    pin_a("wrap", 2, 2, 1, 0);

    send(32'h1111_0000, 32'h2222_0000, 1'b1);
    send(32'h3333_0000, 32'h1111_0000, 1'b0);
    chk("hazard_b_c0", 32'(b_code[2:0]), 32'd1);
    chk("hazard_b_c1", 32'(b_code[5:3]), 32'd1);
    chk("hazard_b_l1", 32'(b_loc[1]),    32'd0);

    @(posedge clk); #2;
    i_ready = 1'b0;
    send(32'h5555_0000, 32'h6666_0000, 1'b0);
    i_valid = 1'b1; i_word = {32'h7777_0000, 32'h5555_0000};
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #2;
      chk("bp_ready", 32'(a_ready), 32'd0);
      chk("bp_hold",  a_word[63:32], 32'h6666_0000);
    end
    i_ready = 1'b1;
    @(posedge clk); #2;
    i_valid = 1'b0; i_word = '0;
    chk("bp_word", a_word[63:32], 32'h7777_0000);
    chk("bp_code", 32'(a_code[2:0]), 32'd2);

    send(32'hCAFE_F00D, 32'h0000_0000, 1'b0);
    send(32'hCAFE_F00D, 32'hCAFE_F00D, 1'b1);
    pin_a("flush", 1, 0, 2, 0);

    send(32'h1234_5678, 32'h0000_0000, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #2;
    chk("midrst_a_valid", 32'(a_valid), 32'd0);
    chk("midrst_b_valid", 32'(b_valid), 32'd0);
    rst_n = 1'b1;
    send(32'h1234_5678, 32'h1234_5678, 1'b0);
    pin_a("postrst", 1, 0, 2, 0);

    repeat (3) @(posedge clk);
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
